// File: rtl/morse_shifter_pkg.sv
// Shared types and constants for the Morse serialiser.
// Patterns are MSB-first, left-aligned in 12 bits.
package morse_shifter_pkg;

   localparam int unsigned MORSE_PAT_W = 12;
   localparam int unsigned MORSE_LEN_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      SHIFT  = 2'd2,
      FINISH = 2'd3
   } state_e;

   localparam logic [11:0] PAT_TBL [8] = '{
      12'b1011_1000_0000,
      12'b1110_1010_1000,
      12'b1110_1011_1010,
      12'b1110_1010_0000,
      12'b1000_0000_0000,
      12'b1010_1110_1000,
      12'b1110_1110_1000,
      12'b1010_1010_0000
   };

   localparam logic [3:0] LEN_TBL [8] = '{
      4'd5, 4'd9, 4'd11, 4'd7,
      4'd1, 4'd9, 4'd9,  4'd7
   };

endpackage

// File: rtl/morse_shifter_if.sv
// Start/tick inputs and serial/status outputs of the serialiser.
interface morse_shifter_if;

   logic       Enable;
   logic       Go;
   logic [2:0] Letter;
   logic       Dout;
   logic       Busy;
   logic       Done;

   modport master (
      output Enable, Go, Letter,
      input  Dout, Busy, Done
   );

   modport slave (
      input  Enable, Go, Letter,
      output Dout, Busy, Done
   );

endinterface

// File: rtl/morse_shifter_lut.sv
// Combinational letter -> {pattern, length} lookup.
module morse_lut
   import morse_shifter_pkg::*;
#(
   parameter int unsigned PAT_W = MORSE_PAT_W,
   parameter int unsigned LEN_W = MORSE_LEN_W
) (
   input  logic [2:0]       letter_i,
   output logic [PAT_W-1:0] pat_o,
   output logic [LEN_W-1:0] len_o
);

   // Wider registers keep the pattern left-aligned with zero padding.
   if (PAT_W == MORSE_PAT_W) begin : g_eq
      assign pat_o = PAT_TBL[letter_i];
   end else begin : g_pad
      assign pat_o = {PAT_TBL[letter_i],
                      {(PAT_W-MORSE_PAT_W){1'b0}}};
   end

   assign len_o = LEN_W'(LEN_TBL[letter_i]);

endmodule

// File: rtl/morse_shifter.sv
// Serialises one Morse letter onto Dout, one unit per Enable tick.
module morse_shifter
   import morse_shifter_pkg::*;
#(
   parameter int unsigned PAT_W = MORSE_PAT_W,
   parameter int unsigned LEN_W = MORSE_LEN_W
) (
   input  logic          Clock,
   input  logic          Resetn,
   morse_shifter_if.slave bus
);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               dout_q, dout_d;
   logic [PAT_W-1:0]   lut_pat;
   logic [LEN_W-1:0]   lut_len;

   morse_lut #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_lut (
      .letter_i (bus.Letter),
      .pat_o    (lut_pat),
      .len_o    (lut_len)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      unique case (state_q)
         IDLE: begin
            dout_d = 1'b0;
            if (bus.Go) begin
               state_d = ARM;
               pat_d   = lut_pat;
               cnt_d   = lut_len;
            end
         end
         ARM: begin
            if (bus.Enable) begin
               dout_d  = pat_q[PAT_W-1];
               pat_d   = {pat_q[PAT_W-2:0], 1'b0};
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.Enable) begin
               if (cnt_q == '0) begin
                  dout_d  = 1'b0;
                  state_d = FINISH;
               end else begin
                  dout_d = pat_q[PAT_W-1];
                  pat_d  = {pat_q[PAT_W-2:0], 1'b0};
                  cnt_d  = cnt_q - LEN_W'(1);
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.Dout = dout_q;
   assign bus.Busy = (state_q != IDLE);
   assign bus.Done = (state_q == FINISH);

endmodule

// File: tb/tb_morse_shifter.sv
// Scoreboard bench: stimulus queues expected units, monitor checks them.
module tb_morse_shifter;

   logic Clock = 1'b0;
   logic Resetn = 1'b0;

   always #5 Clock = ~Clock;

   morse_shifter_if bus ();

   morse_shifter dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   int tests = 0;
   int fails = 0;
   int q[$];

   string pats [8] = '{
      "10111", "111010101", "11101011101", "1110101",
      "1", "101011101", "111011101", "1010101"
   };

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic pop_chk(input string nm, input int act);
      int e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: unexpected output %0d, queue empty", nm, act);
      end else begin
         e = q.pop_front();
         chk(nm, act, e);
      end
   endtask

   // 0/1 = expected Dout after a tick, 2 = expected Done pulse
   logic pb = 1'b0, pe = 1'b0, pd = 1'b0;
   initial begin : mon
      forever begin
         @(negedge Clock);
         if (!Resetn) begin
            pb = 1'b0; pe = 1'b0; pd = 1'b0;
         end else begin
            if (pb && pe && !pd) pop_chk("unit", int'(bus.Dout));
            if (bus.Done) pop_chk("done", 2);
            pb = bus.Busy; pe = bus.Enable; pd = bus.Done;
         end
      end
   end

   task automatic step(input logic go, input logic [2:0] l,
                       input logic en);
      @(posedge Clock);
      #1;
      bus.Go = go;
      bus.Letter = l;
      bus.Enable = en;
   endtask

   task automatic push_letter(input int l);
      for (int i = 0; i < pats[l].len(); i++)
         q.push_back(pats[l][i] == "1" ? 1 : 0);
      q.push_back(0);
      q.push_back(2);
   endtask

   task automatic run_letter(input int l, input int per, input logic go_en,
                             input int rep_at, input string tag);
      logic en;
      logic go;
      logic busy_ok;
      int   done_c;
      push_letter(l);
      step(1'b1, 3'(l), go_en);
      busy_ok = 1'b1;
      done_c = -1;
      for (int c = 0; c < 300; c++) begin
         en = (per == 1) || (c % per == per - 1);
         go = (c == rep_at);
         step(go, go ? 3'd7 : 3'(l), en);
         if (c == 0) begin
            chk({tag, "_dout_after_go"}, int'(bus.Dout), 0);
            chk({tag, "_busy_after_go"}, int'(bus.Busy), 1);
         end
         if (!bus.Busy) busy_ok = 1'b0;
         if (bus.Done) begin
            done_c = c;
            break;
         end
      end
      chk({tag, "_busy_held"}, int'(busy_ok), 1);
      chk({tag, "_done_cycle"}, done_c, (pats[l].len() + 1) * per);
   endtask

   initial begin : stim
      logic ok;
      bus.Go = 1'b0;
      bus.Enable = 1'b0;
      bus.Letter = 3'd0;
      repeat (3) @(posedge Clock);
      #1;
      chk("rst_dout", int'(bus.Dout), 0);
      chk("rst_busy", int'(bus.Busy), 0);
      chk("rst_done", int'(bus.Done), 0);
      @(negedge Clock);
      Resetn = 1'b1;
      step(1'b0, 3'd0, 1'b0);

      run_letter(0, 4, 1'b0, -1, "A");
      repeat (2) step(1'b0, 3'd0, 1'b0);

      run_letter(4, 1, 1'b0, -1, "E");
      repeat (2) step(1'b0, 3'd0, 1'b0);

      run_letter(2, 2, 1'b0, 12, "C_repulse");
      repeat (2) step(1'b0, 3'd0, 1'b0);

      // B interrupted by reset after three units (Dout=1 at that point)
      q.push_back(1); q.push_back(1); q.push_back(1);
      step(1'b1, 3'd1, 1'b0);
      for (int c = 0; c < 6; c++) step(1'b0, 3'd1, c % 2 == 1);
      step(1'b0, 3'd1, 1'b0);
      @(negedge Clock);
      chk("B_pre_rst_dout", int'(bus.Dout), 1);
      #2;
      Resetn = 1'b0;
      #1;
      chk("B_rst_dout", int'(bus.Dout), 0);
      chk("B_rst_busy", int'(bus.Busy), 0);
      chk("B_rst_done", int'(bus.Done), 0);
      q.delete();
      @(posedge Clock);
      #3;
      Resetn = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 3'd1, 1'b1);
         if (bus.Busy || bus.Dout || bus.Done) ok = 1'b0;
      end
      chk("B_quiet_after_rst", int'(ok), 1);
      step(1'b0, 3'd0, 1'b0);

      run_letter(6, 4, 1'b1, -1, "G_go_en");
      repeat (2) step(1'b0, 3'd0, 1'b0);

      for (int l = 0; l < 8; l++) run_letter(l, 1, 1'b0, -1, "b2b");

      repeat (5) step(1'b0, 3'd0, 1'b0);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
